// File: rtl/hafsa_sopc_cpu_oci_trace_capture_pkg.sv
// Shared types and default sizes for the OCI trace capture block.
package hafsa_sopc_trace_pkg;

    localparam int DEF_DATA_W = 30;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/hafsa_sopc_cpu_oci_trace_capture_if.sv
// Show-ahead read channel of the trace capture buffer.
interface hafsa_sopc_cpu_oci_trace_capture_if #(
    parameter int DATA_W = hafsa_sopc_trace_pkg::DEF_DATA_W
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/hafsa_sopc_cpu_oci_trace_capture_fifo.sv
// Trace word storage with pointers and occupancy; WRAP_MODE=1 overwrites the oldest word when full.
module hafsa_sopc_trace_fifo #(
    parameter int DATA_W    = 30,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              full;
    logic              empty;
    logic              do_wr;
    logic              do_rd;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // A full write always retires the oldest slot, whether via a real pop or an overwrite.
    assign do_wr = push && (!full || pop || (WRAP_MODE != 0));
    assign do_rd = (pop && !empty) || (do_wr && full);

    always_comb begin
        level_nxt = level;
        if (do_wr && !do_rd)
            level_nxt = level + 1'b1;
        else if (!do_wr && do_rd)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_wr)
                wp <= wp + 1'b1;
            if (do_rd)
                rp <= rp + 1'b1;
            level <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wp] <= wr_data;
    end

    assign rd_data = mem[rp];

endmodule

// File: rtl/hafsa_sopc_cpu_oci_trace_capture.sv
// OCI trace capture: edge-detects dct_count, buffers trace words, drains at test end.
// Optional saturating drop counter enabled by macro TRACE_CAPTURE_DROP_CNT_EN.
module hafsa_sopc_cpu_oci_trace_capture
    import hafsa_sopc_trace_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WRAP_MODE = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               dct_buffer,
    input  logic [CNT_W-1:0]                dct_count,
    input  logic                            test_ending,
    input  logic                            test_has_ended,
    hafsa_sopc_cpu_oci_trace_capture_if.master rd,
    output logic [$clog2(DEPTH):0]          level,
    output logic [1:0]                      state,
    output logic [15:0]                     drop_count
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t             st;
    logic [CNT_W-1:0]   cnt_q;
    logic               push;
    logic               pop;
    logic [LVL_W-1:0]   level_nxt;

    assign push        = (dct_count != cnt_q) && (st == ST_CAPTURE);
    assign rd.rd_valid = (level != '0) && (st != ST_DONE);
    assign pop         = rd.rd_valid && rd.rd_ready;
    assign state       = st;

    hafsa_sopc_trace_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_data   (dct_buffer),
        .rd_data   (rd.rd_data),
        .level     (level),
        .level_nxt (level_nxt)
    );

    // DONE is judged on the post-update occupancy so a final pop can finish the test.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_CAPTURE;
            cnt_q <= '0;
        end else begin
            cnt_q <= dct_count;
            case (st)
                ST_CAPTURE: begin
                    if (test_has_ended && (level_nxt == '0))
                        st <= ST_DONE;
                    else if (test_ending || test_has_ended)
                        st <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (test_has_ended && (level_nxt == '0))
                        st <= ST_DONE;
                end
                default: st <= st;
            endcase
        end
    end

`ifdef TRACE_CAPTURE_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = push && (level == LVL_W'(DEPTH)) && ((WRAP_MODE != 0) || !pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_q <= '0;
        else if (drop && (drop_q != '1))
            drop_q <= drop_q + 16'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_hafsa_sopc_cpu_oci_trace_capture.sv
// Bench for the trace capture block: drop and wrap variants side by side against a queue model.
module tb_hafsa_sopc_cpu_oci_trace_capture;

    localparam int DW    = 30;
    localparam int CW    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
`ifdef TRACE_CAPTURE_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dct_buffer;
    logic [CW-1:0] dct_count;
    logic          test_ending;
    logic          test_has_ended;
    logic          rd_ready;
    logic [LW-1:0] level0, level1;
    logic [1:0]    state0, state1;
    logic [15:0]   drop0, drop1;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    hafsa_sopc_cpu_oci_trace_capture_if #(.DATA_W(DW)) rd0 ();
    hafsa_sopc_cpu_oci_trace_capture_if #(.DATA_W(DW)) rd1 ();
    assign rd0.rd_ready = rd_ready;
    assign rd1.rd_ready = rd_ready;

    hafsa_sopc_cpu_oci_trace_capture #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd(rd0),
        .level(level0), .state(state0), .drop_count(drop0)
    );

    hafsa_sopc_cpu_oci_trace_capture #(
        .DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd(rd1),
        .level(level1), .state(state1), .drop_count(drop1)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 drops when full, index 1 overwrites the oldest.
    logic [DW-1:0] mq [2][$];
    int            mstate [2];
    int unsigned   mdrop [2];
    logic [CW-1:0] mcnt [2];

    typedef struct {
        logic [CW-1:0] cnt;
        logic [DW-1:0] data;
        logic          ready;
        int            lvl;
        logic          vld;
        logic [DW-1:0] dat;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mstate[k] = 0;
            mdrop[k]  = 0;
            mcnt[k]   = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit push, pop, full;
            push = (dct_count != mcnt[k]) && (mstate[k] == 0);
            pop  = (mq[k].size() != 0) && (mstate[k] != 2) && rd_ready;
            full = (mq[k].size() == DEPTH);
            if (push && !full) begin
                if (pop) void'(mq[k].pop_front());
                mq[k].push_back(dct_buffer);
            end else if (push) begin
                if (k == 1 || pop) begin
                    void'(mq[k].pop_front());
                    mq[k].push_back(dct_buffer);
                end
                if ((k == 1 || !pop) && mdrop[k] < 65535) mdrop[k]++;
            end else if (pop) begin
                void'(mq[k].pop_front());
            end
            mcnt[k] = dct_count;
            if (mstate[k] != 2) begin
                if (test_has_ended && mq[k].size() == 0) mstate[k] = 2;
                else if (mstate[k] == 0 && (test_ending || test_has_ended)) mstate[k] = 1;
            end
        end
    endtask

    task automatic chk_dut(input int k, input logic [LW-1:0] lv, input logic vd,
                           input logic [DW-1:0] dt, input logic [1:0] st, input logic [15:0] dc);
        bit ev;
        ev = (mq[k].size() != 0) && (mstate[k] != 2);
        check($sformatf("m%0d_level", k), 32'(lv), mq[k].size());
        check($sformatf("m%0d_valid", k), 32'(vd), 32'(ev));
        check($sformatf("m%0d_state", k), 32'(st), mstate[k]);
        check($sformatf("m%0d_drop", k), 32'(dc), DROP_EN != 0 ? mdrop[k] : 0);
        if (ev) check($sformatf("m%0d_data", k), 32'(dt), 32'(mq[k][0]));
    endtask

    task automatic check_model();
        chk_dut(0, level0, rd0.rd_valid, rd0.rd_data, state0, drop0);
        chk_dut(1, level1, rd1.rd_valid, rd1.rd_data, state1, drop1);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        rd_ready       = 1'b0;
        dct_count      = '0;
        reset          = 1'b1;
        model_reset();
        #1;
        check_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{cnt: 4'd1, data: 30'd1, ready: 1'b1, lvl: 1, vld: 1'b1, dat: 30'd1};
        tbl[1] = '{cnt: 4'd2, data: 30'd2, ready: 1'b1, lvl: 1, vld: 1'b1, dat: 30'd2};
        tbl[2] = '{cnt: 4'd3, data: 30'd3, ready: 1'b1, lvl: 1, vld: 1'b1, dat: 30'd3};
        tbl[3] = '{cnt: 4'd4, data: 30'd4, ready: 1'b1, lvl: 1, vld: 1'b1, dat: 30'd4};
        tbl[4] = '{cnt: 4'd5, data: 30'd5, ready: 1'b1, lvl: 1, vld: 1'b1, dat: 30'd5};
        tbl[5] = '{cnt: 4'd5, data: 30'd0, ready: 1'b1, lvl: 0, vld: 1'b0, dat: 30'd0};

        dct_buffer = '0;
        do_reset();
        check("rst_level", 32'(level0), 0);
        check("rst_state", 32'(state0), 0);
        check("rst_valid", 32'(rd0.rd_valid), 0);
        check("rst_drop", 32'(drop0), 0);

        // In-order pass-through of five words.
        for (int i = 0; i < 6; i++) begin
            dct_count  = tbl[i].cnt;
            dct_buffer = tbl[i].data;
            rd_ready   = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_level", i), 32'(level0), tbl[i].lvl);
            check($sformatf("tbl%0d_valid", i), 32'(rd0.rd_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) check($sformatf("tbl%0d_data", i), 32'(rd0.rd_data), 32'(tbl[i].dat));
        end
        check("pass_drop", 32'(drop0), 0);

        // Overflow: 20 pushes, no reader.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            dct_count  = 4'(i);
            dct_buffer = DW'(i);
            step();
        end
        check("ovf0_level", 32'(level0), 16);
        check("ovf0_oldest", 32'(rd0.rd_data), 1);
        check("ovf0_drop", 32'(drop0), 4 * DROP_EN);
        check("ovf1_level", 32'(level1), 16);
        check("ovf1_oldest", 32'(rd1.rd_data), 5);
        check("ovf1_drop", 32'(drop1), 4 * DROP_EN);

        // Push and pop together while full.
        dct_count  = 4'd5;
        dct_buffer = 30'd21;
        rd_ready   = 1'b1;
        step();
        check("fpp0_level", 32'(level0), 16);
        check("fpp0_drop", 32'(drop0), 4 * DROP_EN);
        check("fpp0_oldest", 32'(rd0.rd_data), 2);
        check("fpp1_level", 32'(level1), 16);
        check("fpp1_drop", 32'(drop1), 5 * DROP_EN);
        check("fpp1_oldest", 32'(rd1.rd_data), 6);
        for (int i = 0; i < 16; i++) begin
            check("drain0_data", 32'(rd0.rd_data), (i < 15) ? i + 2 : 21);
            check("drain1_data", 32'(rd1.rd_data), i + 6);
            step();
        end
        check("drain_level", 32'(level0), 0);
        check("drain_valid", 32'(rd1.rd_valid), 0);

        // End-of-test drain with the OCI still counting.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            dct_count  = 4'(i);
            dct_buffer = DW'(i);
            step();
        end
        test_ending = 1'b1;
        step();
        check("end_state", 32'(state0), 1);
        check("end_level", 32'(level0), 3);
        for (int i = 4; i <= 7; i++) begin
            dct_count  = 4'(i);
            dct_buffer = DW'(100 + i);
            step();
        end
        check("end_nostore", 32'(level0), 3);
        rd_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("end_pop_data", 32'(rd0.rd_data), i);
            dct_count = dct_count + 4'd1;
            step();
        end
        check("end_empty_state", 32'(state0), 1);
        check("end_empty_valid", 32'(rd0.rd_valid), 0);
        test_has_ended = 1'b1;
        step();
        check("done_state", 32'(state0), 2);
        check("done_valid", 32'(rd0.rd_valid), 0);
        dct_count = dct_count + 4'd1;
        step();
        check("done_frozen", 32'(level0), 0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            dct_count  = 4'(i);
            dct_buffer = DW'(i);
            step();
        end
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        check("mid_state", 32'(state0), 1);
        check("mid_level", 32'(level0), 7);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_level", 32'(level0), 0);
        check("arst_state", 32'(state0), 0);
        check("arst_valid", 32'(rd0.rd_valid), 0);
        check_model();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dct_buffer = 30'd99;
        step();
        check("post_rst_push", 32'(level0), 1);
        check("post_rst_data", 32'(rd0.rd_data), 99);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 1) dct_count = dct_count + 4'(1 + $urandom_range(0, 14));
                dct_buffer     = DW'($urandom);
                rd_ready       = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                test_ending    = ($urandom_range(0, 299) == 0);
                test_has_ended = ($urandom_range(0, 199) == 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/hafsa_sopc_cpu_oci_trace_capture.md
HAFSA_SOPC_CPU_OCI_TRACE_CAPTURE -- requirements
Module: hafsa_sopc_cpu_oci_trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 30, width of one trace word.
REQ-002 SHALL have parameter CNT_W, default 4, width of the OCI trace count.
REQ-003 SHALL have parameter DEPTH, default 16, buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter WRAP_MODE, default 0; 0 drops new words when full, 1 overwrites the oldest.
REQ-005 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port dct_buffer  in  DATA_W  trace word from OCI.
REQ-008 SHALL have port dct_count  in  CNT_W  OCI trace counter; any change marks a completed word.
REQ-009 SHALL have port test_ending  in  1  level; stop capturing and drain.
REQ-010 SHALL have port test_has_ended  in  1  level; test finished.
REQ-011 SHALL have port rd_ready  in  1  consumer accepts rd_data.
REQ-012 SHALL have port rd_valid  out  1  rd_data holds the oldest stored word.
REQ-013 SHALL have port rd_data  out  DATA_W  oldest stored word (show-ahead).
REQ-014 SHALL have port level  out  $clog2(DEPTH)+1  entries stored.
REQ-015 SHALL have port state  out  2  CAPTURE=0, DRAIN=1, DONE=2.
REQ-016 SHALL have port drop_count  out  16  saturating count of lost words.

Function
REQ-017 SHALL register dct_count into cnt_q each cycle; push request = (dct_count != cnt_q) in CAPTURE, capturing dct_buffer of that cycle.
REQ-018 SHALL ignore push requests in DRAIN and DONE, without counting them as drops.
REQ-019 SHALL drive rd_valid = (level != 0) and state != DONE; pop occurs when rd_valid and rd_ready.
REQ-020 SHALL make a pushed word visible on rd_data one cycle after the push edge; no same-cycle bypass.
REQ-021 SHALL, on push and pop in the same cycle with 0 < level < DEPTH, keep level unchanged and perform both.
REQ-022 SHALL, when full with WRAP_MODE=0, drop a push without a pop and increment drop_count; a simultaneous pop and push are both accepted.
REQ-023 SHALL, when full with WRAP_MODE=1, write the new word, advance the read pointer, keep level at DEPTH and increment drop_count; a simultaneous pop is then ignored.
REQ-024 SHALL use modulo-DEPTH read and write pointers that wrap from DEPTH-1 to 0.
REQ-025 SHALL saturate drop_count at 16'hFFFF.
REQ-026 SHALL move CAPTURE->DRAIN when test_ending=1, or when test_has_ended=1 and level!=0.
REQ-027 SHALL move CAPTURE or DRAIN ->DONE when test_has_ended=1 and level==0, with level evaluated after any pop that cycle.
REQ-028 SHALL treat DONE as terminal until reset; the buffer is frozen and rd_valid=0.

Reset
REQ-029 SHALL on reset set state=CAPTURE, pointers=0, level=0, rd_valid=0, drop_count=0, cnt_q=0.
REQ-030 SHALL discard all buffered words on reset mid-drain; the first push after release compares against cnt_q=0.
REQ-031 SHALL not reset buffer storage; rd_data is don't-care while rd_valid=0.

Configuration
REQ-032 SHALL honour macro TRACE_CAPTURE_DROP_CNT_EN: when defined, drop_count behaves per REQ-022/023/025; when undefined, drop_count is tied to 0 and its counter is not built. The port is present in both cases.

Structure
REQ-033 SHALL place the state encoding (typedef enum) and the default DATA_W/CNT_W/DEPTH constants in package hafsa_sopc_trace_pkg.
REQ-034 SHALL implement storage, pointers and level in sub-module hafsa_sopc_trace_fifo; the FSM, edge detect and drop counter live in the top.

Verification
REQ-035 SHALL verify: DEPTH=16, 5 count changes with words 1..5, rd_ready=1 -> rd_data 1..5 in order, level ends at 0, drop_count=0.
REQ-036 SHALL verify: WRAP_MODE=0, 20 pushes with rd_ready=0 -> level=16, words 1..16 retained, drop_count=4.
REQ-037 SHALL verify: WRAP_MODE=1, 20 pushes with rd_ready=0 -> level=16, oldest word 5, drop_count=4.
REQ-038 SHALL verify: test_ending with level=3, pushes continuing -> state=DRAIN, no further stores, 3 pops; test_has_ended then -> state=DONE, rd_valid=0.
REQ-039 SHALL verify: reset asserted mid-drain at level=7 -> level=0, state=CAPTURE, rd_valid=0 in the same cycle, asynchronously.
REQ-040 SHALL verify: full with push and pop in the same cycle, WRAP_MODE=0 -> level stays 16, no drop counted.
